// File: rtl/cpu_step_clock.sv
// Processor clock generator: debounced single-step, free-run at 2^rate_sel
// half-period, and run-to-breakpoint on a PC match. Drives the CPU's clock.
`timescale 1ns/1ps
module cpu_step_clock #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_n,
    input  logic [1:0]  mode,
    input  logic [3:0]  rate_sel,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] pc,
    output logic        cpu_clock,
    output logic [15:0] step_count,
    output logic        halted,
    output logic        bp_hit
);

    localparam logic [1:0] MODE_STEP   = 2'b00;
    localparam logic [1:0] MODE_RUN    = 2'b01;
    localparam logic [1:0] MODE_RUN_BP = 2'b10;

    // Counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_BRK} state_t;

    logic [1:0]    key_sync;
    logic          db_level;
    logic          db_level_d;
    logic [CW-1:0] db_cnt;
    logic          press;

    state_t        state;
    logic [3:0]    h_exp;
    logic [15:0]   ph_cnt;
    logic          ph_last;
    logic          bp_match;
    logic          idle_go;

    // Two-flop synchronizer; idles at the released (high) level.
    always_ff @(posedge clock) begin
        if (reset) key_sync <= 2'b11;
        else       key_sync <= {key_sync[0], key_n};
    end

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing
    // samples; press is a registered one-cycle pulse on an accepted 1->0 change.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_level   <= 1'b1;
            db_level_d <= 1'b1;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            db_level_d <= db_level;
            press      <= db_level_d & ~db_level;
            if (key_sync[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= key_sync[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Phase ends when the counter reaches H-1, H latched at step start.
    assign ph_last  = (ph_cnt == ((16'd1 << h_exp) - 16'd1));
    assign bp_match = bp_en && (pc == bp_addr);
    assign idle_go  = ((mode == MODE_STEP) && press) ||
                      (mode == MODE_RUN) ||
                      ((mode == MODE_RUN_BP) && !bp_match);

    // Step FSM; mode/rate only matter at the IDLE and BRK decision points.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cpu_clock  <= 1'b0;
            step_count <= '0;
            halted     <= 1'b1;
            bp_hit     <= 1'b0;
            h_exp      <= '0;
            ph_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((mode == MODE_RUN_BP) && bp_match) begin
                        state  <= S_BRK;
                        bp_hit <= 1'b1;
                    end else if (idle_go) begin
                        state      <= S_HIGH;
                        cpu_clock  <= 1'b1;
                        step_count <= step_count + 16'd1;
                        halted     <= 1'b0;
                        h_exp      <= rate_sel;
                        ph_cnt     <= '0;
                    end
                end
                S_HIGH: begin
                    if (ph_last) begin
                        state     <= S_LOW;
                        cpu_clock <= 1'b0;
                        ph_cnt    <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 16'd1;
                    end
                end
                S_LOW: begin
                    if (ph_last) begin
                        state  <= S_IDLE;
                        halted <= 1'b1;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 16'd1;
                    end
                end
                S_BRK: begin
                    // A press steps past the breakpoint regardless of pc.
                    if (press) begin
                        state      <= S_HIGH;
                        cpu_clock  <= 1'b1;
                        step_count <= step_count + 16'd1;
                        halted     <= 1'b0;
                        bp_hit     <= 1'b0;
                        h_exp      <= rate_sel;
                        ph_cnt     <= '0;
                    end else if (mode != MODE_RUN_BP) begin
                        state  <= S_IDLE;
                        bp_hit <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cpu_clock <= 1'b0;
                    halted    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_clock.sv
// Bench for cpu_step_clock: randomized scenarios checked against timing
// predicted from the block's rules (latency D+3, period 2H+1, bp stop count).
`timescale 1ns/1ps
module tb_cpu_step_clock;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_n;
    logic [1:0]  mode;
    logic [3:0]  rate_sel;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] pc;
    logic        cpu_clock;
    logic [15:0] step_count;
    logic        halted;
    logic        bp_hit;

    int checks   = 0;
    int failures = 0;

    // Edge log owned by the monitor.
    int   cyc    = 0;
    int   n_rise = 0;
    int   n_fall = 0;
    int   rise_at [512];
    int   fall_at [512];
    logic prev_cc = 1'b0;

    // Processor PC model: base plus 2 per cpu_clock rise since trk0.
    logic [15:0] pc_base;
    logic        pc_track;
    int          trk0;
    assign pc = pc_track ? pc_base + 16'(2 * (n_rise - trk0)) : pc_base;

    cpu_step_clock #(.DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .mode       (mode),
        .rate_sel   (rate_sel),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_clock  (cpu_clock),
        .step_count (step_count),
        .halted     (halted),
        .bp_hit     (bp_hit)
    );

    always #5 clock = ~clock;

    // Log cpu_clock edges by the board-clock edge that produced them.
    always @(posedge clock) begin
        cyc = cyc + 1;
        #2;
        if (cpu_clock && !prev_cc) begin
            if (n_rise < 512) rise_at[n_rise] = cyc;
            n_rise = n_rise + 1;
        end
        if (!cpu_clock && prev_cc) begin
            if (n_fall < 512) fall_at[n_fall] = cyc;
            n_fall = n_fall + 1;
        end
        prev_cc = cpu_clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_rises(input string tag, input int target, input int bound);
        int n = 0;
        while (n_rise < target && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_reached"}, 32'(n_rise >= target), 32'd1);
    endtask

    int e0, r0, f0, h, nsteps, k, exp_steps, bound, n;

    initial begin
        reset = 1'b1; key_n = 1'b1; mode = 2'b11; rate_sel = 4'd0;
        bp_en = 1'b0; bp_addr = 16'd0; pc_base = 16'd0; pc_track = 1'b0; trk0 = 0;
        exp_steps = 0;
        tick(3);
        chk("rst_cpu_clock", 32'(cpu_clock), 32'd0);
        chk("rst_step_count", 32'(step_count), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        reset = 1'b0;
        tick(2);

        // Debounce and single step, glitches shorter than D are ignored.
        mode = 2'b00; rate_sel = 4'd1; r0 = n_rise; f0 = n_fall;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            key_n = 1'b0; tick($urandom_range(1, D - 1));
            key_n = 1'b1; tick($urandom_range(1, 3));
        end
        key_n = 1'b0; e0 = cyc + 1;
        wait_rises("step1", r0 + 1, 30);
        chk("step1_halted_busy", 32'(halted), 32'd0);
        chk("step1_cpu_high", 32'(cpu_clock), 32'd1);
        tick(15);
        chk("step1_rise_at", 32'(rise_at[r0] - e0), 32'(D + 3));
        chk("step1_high_len", 32'(fall_at[f0] - rise_at[r0]), 32'd2);
        chk("step1_rises", 32'(n_rise - r0), 32'd1);
        exp_steps = 1;
        chk("step1_count", 32'(step_count), 32'(exp_steps));
        key_n = 1'b1; tick(12);
        key_n = 1'b0; tick(20);
        key_n = 1'b1; tick(12);
        exp_steps = 2;
        chk("step2_count", 32'(step_count), 32'(exp_steps));
        chk("step2_rises", 32'(n_rise - r0), 32'd2);

        // Free run; second pass is RUN_BP with bp_en=0 and pc on bp_addr.
        for (int run = 0; run < 2; run++) begin
            rate_sel = (run == 0) ? 4'd2 : 4'($urandom_range(0, 3));
            h = 1 << rate_sel;
            nsteps = (run == 0) ? 21 : int'($urandom_range(5, 12));
            bp_en = 1'b0; bp_addr = 16'($urandom); pc_base = bp_addr; pc_track = 1'b0;
            r0 = n_rise; f0 = n_fall;
            mode = (run == 0) ? 2'b01 : 2'b10;
            e0 = cyc + 1;
            wait_rises("run", r0 + nsteps, nsteps * (2 * h + 1) + 10);
            mode = 2'b11;
            rate_sel = 4'($urandom);
            tick(4 * h + 10);
            chk("run_first_rise", 32'(rise_at[r0]), 32'(e0));
            for (int i = 0; i < nsteps - 1; i++)
                chk("run_period", 32'(rise_at[r0 + i + 1] - rise_at[r0 + i]), 32'(2 * h + 1));
            for (int i = 0; i < nsteps; i++)
                chk("run_high", 32'(fall_at[f0 + i] - rise_at[r0 + i]), 32'(h));
            chk("hold_rises", 32'(n_rise - r0), 32'(nsteps));
            chk("hold_falls", 32'(n_fall - f0), 32'(nsteps));
            exp_steps += nsteps;
            chk("run_count", 32'(step_count), 32'(exp_steps));
            chk("hold_halted", 32'(halted), 32'd1);
            chk("hold_cpu_low", 32'(cpu_clock), 32'd0);
        end

        // Run to breakpoint at pc = 2k, then press through it.
        rate_sel = 4'($urandom_range(0, 2)); h = 1 << rate_sel;
        k = $urandom_range(1, 5);
        bp_en = 1'b1; bp_addr = 16'(2 * k); pc_base = 16'd0;
        trk0 = n_rise; r0 = n_rise; pc_track = 1'b1;
        mode = 2'b10;
        bound = (k + 2) * (2 * h + 1) + 10; n = 0;
        while (!bp_hit && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk("bp_stop", 32'(bp_hit), 32'd1);
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_cpu_low", 32'(cpu_clock), 32'd0);
        chk("bp_steps", 32'(n_rise - r0), 32'(k));
        tick(10);
        chk("bp_stays", 32'(n_rise - r0), 32'(k));
        exp_steps += k;
        chk("bp_count", 32'(step_count), 32'(exp_steps));
        key_n = 1'b0; e0 = cyc + 1;
        wait_rises("bp_press", r0 + k + 1, 30);
        chk("bp_press_rise_at", 32'(rise_at[r0 + k] - e0), 32'(D + 3));
        chk("bp_cleared", 32'(bp_hit), 32'd0);
        wait_rises("bp_resume", r0 + k + 4, 6 * (2 * h + 1) + 10);
        mode = 2'b11; key_n = 1'b1;
        tick(4 * h + 20);
        exp_steps += 4;
        chk("bp_resume_rises", 32'(n_rise - r0), 32'(k + 4));
        chk("bp_resume_count", 32'(step_count), 32'(exp_steps));

        // Leaving BRK by switching to STEP.
        pc_track = 1'b0; pc_base = bp_addr; r0 = n_rise;
        mode = 2'b10; tick(3);
        chk("brk_enter", 32'(bp_hit), 32'd1);
        chk("brk_halted", 32'(halted), 32'd1);
        mode = 2'b00; tick(3);
        chk("brk_exit_bp_hit", 32'(bp_hit), 32'd0);
        chk("brk_exit_halted", 32'(halted), 32'd1);
        chk("brk_exit_rises", 32'(n_rise - r0), 32'd0);
        chk("brk_exit_count", 32'(step_count), 32'(exp_steps));
        mode = 2'b11; bp_en = 1'b0;

        // Step counter wrap from 0xFFFF.
        force dut.step_count = 16'hFFFF;
        tick(1);
        release dut.step_count;
        tick(1);
        chk("wrap_preload", 32'(step_count), 32'h0000_FFFF);
        rate_sel = 4'd0; r0 = n_rise;
        mode = 2'b01; tick(1);
        mode = 2'b11; tick(8);
        chk("wrap_rises", 32'(n_rise - r0), 32'd1);
        chk("wrap_count", 32'(step_count), 32'd0);

        // Reset in the middle of a high phase.
        rate_sel = 4'd3; r0 = n_rise;
        mode = 2'b01;
        wait_rises("rst_mid", r0 + 1, 5);
        tick(2);
        chk("rst_mid_high", 32'(cpu_clock), 32'd1);
        reset = 1'b1; tick(1);
        chk("rst_mid_cpu_clock", 32'(cpu_clock), 32'd0);
        chk("rst_mid_count", 32'(step_count), 32'd0);
        chk("rst_mid_halted", 32'(halted), 32'd1);
        chk("rst_mid_bp_hit", 32'(bp_hit), 32'd0);
        mode = 2'b11; tick(2);
        reset = 1'b0; tick(20);
        chk("post_rst_count", 32'(step_count), 32'd0);
        chk("post_rst_cpu_clock", 32'(cpu_clock), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
